// File: rtl/student_fir_sched_pkg.sv
// Shared types and helpers for the FIR sample sequencer.
package student_fir_sched_pkg;

  // Sequencer states: wait for work, strobe the FIR, wait for its result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  // Origin of a sample, carried through to the result tag.
  typedef enum logic {
    SRC_STREAM = 1'b0,
    SRC_SW     = 1'b1
  } sched_src_t;

  localparam int DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/student_fir_sched_fifo.sv
// Small synchronous first-word-fall-through FIFO for the audio stream.
// The head entry is read combinationally so the sequencer can load it on
// the same edge that pops it.
module student_fir_sched_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == LW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign level_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  // Requests are qualified here as well, so a push at full or a pop at
  // empty can never corrupt the pointers.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Storage: contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/student_fir_sched.sv
// Sequencer in front of the FIR: merges a buffered sample stream with a
// software-injected sample slot, strobes one sample at a time into the FIR,
// waits (bounded) for the result and holds it on a valid/ready output.
module student_fir_sched
  import student_fir_sched_pkg::*;
#(
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 24,
  parameter int FIFO_DEPTH        = 4,
  parameter int TIMEOUT_CYCLES    = 2048
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               clr_i,
  input  logic [DATA_SIZE-1:0]               s_sample_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  input  logic [DATA_SIZE-1:0]               sw_sample_i,
  input  logic                               sw_req_i,
  output logic                               sw_pending_o,
  output logic                               fir_strobe_o,
  output logic [DATA_SIZE-1:0]               fir_sample_o,
  input  logic                               fir_valid_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0]       fir_y_i,
  output logic [DATA_SIZE_FIR_OUT-1:0]       m_y_o,
  output logic                               m_src_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               busy_o,
  output logic                               timeout_o,
  output logic [DROP_CNT_W-1:0]              drop_cnt_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  sched_state_t                   r_state;
  sched_state_t                   w_state_next;
  sched_src_t                     r_src;
  sched_src_t                     r_m_src;
  logic                           r_ready_en;
  logic                           r_sw_pending;
  logic [DATA_SIZE-1:0]           r_sw_sample;
  logic [DROP_CNT_W-1:0]          r_drop_cnt;
  logic                           r_timeout;
  logic [DATA_SIZE-1:0]           r_fir_sample;
  logic [CNT_W-1:0]               r_wait_cnt;
  logic [DATA_SIZE_FIR_OUT-1:0]   r_m_y;
  logic                           r_m_valid;

  logic                           w_fifo_full;
  logic                           w_fifo_empty;
  logic [DATA_SIZE-1:0]           w_fifo_data;
  logic [$clog2(FIFO_DEPTH+1)-1:0] w_fifo_level;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_issue;
  logic                           w_sel_sw;
  logic                           w_sw_issue;
  logic                           w_capture;
  logic                           w_timeout;
  logic                           w_drop;

  // ---------------------------------------------------------------------
  // Stream buffer
  // ---------------------------------------------------------------------
  // s_ready_o is held low while in reset and for the first edge after it,
  // and otherwise only reflects registered FIFO state.
  assign s_ready_o = r_ready_en && !w_fifo_full;
  assign w_push    = s_valid_i && s_ready_o;
  assign w_pop     = w_issue && !w_sel_sw;

  student_fir_sched_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (s_sample_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .level_o (w_fifo_level)
  );

  // Stream-accept enable, released one edge after reset deasserts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration: software wins unless it also won last time and stream
  // data is waiting, which makes the two sources alternate under load.
  // ---------------------------------------------------------------------
  assign w_sel_sw   = r_sw_pending && !((r_src == SRC_SW) && !w_fifo_empty);
  assign w_sw_issue = w_issue && w_sel_sw;
  // A new request only counts as a drop if it replaces a sample that is
  // not being issued on this very edge.
  assign w_drop     = sw_req_i && r_sw_pending && !w_sw_issue;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the single-cycle decision strobes.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        // An unconsumed result blocks issue, so it can never be overwritten.
        if (en_i && (r_sw_pending || !w_fifo_empty) && (!r_m_valid || m_ready_i)) begin
          w_issue      = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_state_next = WAIT;
      end
      WAIT: begin
        if (fir_valid_i) begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign fir_strobe_o = (r_state == ISSUE);
  assign busy_o       = (r_state != IDLE);

  // Sample and source selected on the issue edge; both hold until the next issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fir_sample <= '0;
      r_src        <= SRC_STREAM;
    end else if (w_issue) begin
      r_fir_sample <= w_sel_sw ? r_sw_sample : w_fifo_data;
      r_src        <= w_sel_sw ? SRC_SW : SRC_STREAM;
    end
  end

  // WAIT-cycle counter: cleared while strobing, counts every WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Software slot and drop counter
  // ---------------------------------------------------------------------
  // A request always lands in the slot; issuing only empties it when no
  // new request arrives on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sw_pending <= 1'b0;
      r_sw_sample  <= '0;
    end else if (sw_req_i) begin
      r_sw_pending <= 1'b1;
      r_sw_sample  <= sw_sample_i;
    end else if (w_sw_issue) begin
      r_sw_pending <= 1'b0;
    end
  end

  // Saturating drop count; a simultaneous drop beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end else if (clr_i) begin
      r_drop_cnt <= '0;
    end
  end

  // Sticky timeout flag; a simultaneous timeout beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_timeout <= 1'b1;
    end else if (clr_i) begin
      r_timeout <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------
  // Capture the FIR result with its tag and hold it until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_y     <= '0;
      r_m_src   <= SRC_STREAM;
      r_m_valid <= 1'b0;
    end else if (w_capture) begin
      r_m_y     <= fir_y_i;
      r_m_src   <= r_src;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready_i) begin
      r_m_valid <= 1'b0;
    end
  end

  assign sw_pending_o = r_sw_pending;
  assign fir_sample_o = r_fir_sample;
  assign m_y_o        = r_m_y;
  assign m_src_o      = r_m_src;
  assign m_valid_o    = r_m_valid;
  assign fifo_level_o = w_fifo_level;
  assign timeout_o    = r_timeout;
  assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_student_fir_sched.sv
// Directed testbench for student_fir_sched with a behavioural FIR and a
// queue-based scoreboard checked by independent strobe/result monitors.
module tb_student_fir_sched;

  localparam int DW      = 16;
  localparam int YW      = 24;
  localparam int DEPTH   = 4;
  localparam int TO      = 2048;
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int FIR_LAT = 10;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic             clr_i;
  logic [DW-1:0]    s_sample_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [DW-1:0]    sw_sample_i;
  logic             sw_req_i;
  logic             sw_pending_o;
  logic             fir_strobe_o;
  logic [DW-1:0]    fir_sample_o;
  logic             fir_valid_i;
  logic [YW-1:0]    fir_y_i;
  logic [YW-1:0]    m_y_o;
  logic             m_src_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [LVL_W-1:0] fifo_level_o;
  logic             busy_o;
  logic             timeout_o;
  logic [15:0]      drop_cnt_o;

  student_fir_sched #(
    .DATA_SIZE         (DW),
    .DATA_SIZE_FIR_OUT (YW),
    .FIFO_DEPTH        (DEPTH),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .s_sample_i   (s_sample_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .sw_sample_i  (sw_sample_i),
    .sw_req_i     (sw_req_i),
    .sw_pending_o (sw_pending_o),
    .fir_strobe_o (fir_strobe_o),
    .fir_sample_o (fir_sample_o),
    .fir_valid_i  (fir_valid_i),
    .fir_y_i      (fir_y_i),
    .m_y_o        (m_y_o),
    .m_src_o      (m_src_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .fifo_level_o (fifo_level_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [YW-1:0] y;
    logic          src;
  } res_t;

  logic [DW-1:0] exp_smp_q [$];
  res_t          exp_res_q [$];
  int            n_checks  = 0;
  int            n_errors  = 0;
  int            n_strobes = 0;
  logic          fir_mute  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_strobe(input logic [DW-1:0] s);
    exp_smp_q.push_back(s);
  endtask

  task automatic exp_result(input logic [YW-1:0] y, input logic src);
    res_t r;
    r.y   = y;
    r.src = src;
    exp_res_q.push_back(r);
  endtask

  // Behavioural FIR: y = 3*x + 0x100, FIR_LAT cycles after the strobe.
  initial begin : fir_model
    logic [DW-1:0] smp;
    fir_valid_i = 1'b0;
    fir_y_i     = '0;
    forever begin
      @(negedge clk);
      if (fir_strobe_o && !fir_mute) begin
        smp = fir_sample_o;
        repeat (FIR_LAT) @(posedge clk);
        #1;
        fir_y_i     = {8'h00, smp} * 24'd3 + 24'h000100;
        fir_valid_i = 1'b1;
        @(posedge clk);
        #1;
        fir_valid_i = 1'b0;
      end
    end
  end

  // Strobe monitor: every strobe is one cycle wide and carries the next expected sample.
  initial begin : strobe_mon
    logic          prev_strobe;
    logic [DW-1:0] e;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (fir_strobe_o) begin
        n_strobes++;
        check("strobe_width", 32'(prev_strobe), 0);
        if (exp_smp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: got sample 0x%0h, required no strobe", fir_sample_o);
        end else begin
          e = exp_smp_q.pop_front();
          check("fir_sample", 32'(fir_sample_o), 32'(e));
        end
        $display("strobe %0d: sample=0x%04h", n_strobes, fir_sample_o);
      end
      prev_strobe = fir_strobe_o;
    end
  end

  // Result monitor: each accepted result matches the next expected value and tag.
  initial begin : result_mon
    res_t r;
    forever begin
      @(negedge clk);
      if (m_valid_o && m_ready_i) begin
        if (exp_res_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got y=0x%0h src=%0d, required no result", m_y_o, m_src_o);
        end else begin
          r = exp_res_q.pop_front();
          check("m_y", 32'(m_y_o), 32'(r.y));
          check("m_src", 32'(m_src_o), 32'(r.src));
        end
        $display("result: y=0x%06h src=%0d", m_y_o, m_src_o);
      end
    end
  end

  task automatic push_stream(input logic [DW-1:0] s);
    int guard;
    guard = 0;
    while (!s_ready_o && guard < 200) begin
      tick();
      guard++;
    end
    check("push_ready", 32'(s_ready_o), 1);
    s_sample_i = s;
    s_valid_i  = 1'b1;
    tick();
    s_valid_i  = 1'b0;
  endtask

  task automatic sw_pulse(input logic [DW-1:0] s);
    sw_sample_i = s;
    sw_req_i    = 1'b1;
    tick();
    sw_req_i    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_smp_q.size() != 0 || exp_res_q.size() != 0 || busy_o) && c < budget) begin
      tick();
      c++;
    end
    check("drain_done", 32'(exp_smp_q.size() + exp_res_q.size()), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", 32'(s_ready_o), 0);
    check("rst_sw_pending", 32'(sw_pending_o), 0);
    check("rst_strobe", 32'(fir_strobe_o), 0);
    check("rst_fir_sample", 32'(fir_sample_o), 0);
    check("rst_m_y", 32'(m_y_o), 0);
    check("rst_m_src", 32'(m_src_o), 0);
    check("rst_m_valid", 32'(m_valid_o), 0);
    check("rst_level", 32'(fifo_level_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_drop", 32'(drop_cnt_o), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   c;
    int   s0;
    logic stable;
    logic saw_valid;

    rst_i       = 1'b1;
    en_i        = 1'b0;
    clr_i       = 1'b0;
    s_valid_i   = 1'b0;
    s_sample_i  = '0;
    sw_req_i    = 1'b0;
    sw_sample_i = '0;
    m_ready_i   = 1'b1;

    // Reset state
    repeat (3) tick();
    check_reset_outputs();
    rst_i = 1'b0;
    tick();
    check("s_ready_after_reset", 32'(s_ready_o), 1);

    // Three stream samples in order
    en_i = 1'b1;
    exp_strobe(16'h0001);
    exp_strobe(16'h0002);
    exp_strobe(16'h0003);
    exp_result(24'h000103, 1'b0);
    exp_result(24'h000106, 1'b0);
    exp_result(24'h000109, 1'b0);
    push_stream(16'h0001);
    push_stream(16'h0002);
    push_stream(16'h0003);
    wait_drain(300);

    // Fill FIFO while disabled, then drain
    en_i = 1'b0;
    s0   = n_strobes;
    push_stream(16'h0010);
    push_stream(16'h0020);
    push_stream(16'h0030);
    push_stream(16'h0040);
    check("full_s_ready", 32'(s_ready_o), 0);
    check("full_level", 32'(fifo_level_o), 4);
    s_sample_i = 16'h0BAD;
    s_valid_i  = 1'b1;
    tick();
    tick();
    s_valid_i  = 1'b0;
    check("full_no_push_level", 32'(fifo_level_o), 4);
    check("disabled_no_strobe", 32'(n_strobes - s0), 0);
    exp_strobe(16'h0010);
    exp_strobe(16'h0020);
    exp_strobe(16'h0030);
    exp_strobe(16'h0040);
    exp_result(24'h000130, 1'b0);
    exp_result(24'h000160, 1'b0);
    exp_result(24'h000190, 1'b0);
    exp_result(24'h0001C0, 1'b0);
    en_i = 1'b1;
    wait_drain(400);

    // Software sample with stream queued: sw first
    en_i = 1'b0;
    push_stream(16'h0A00);
    push_stream(16'h0B00);
    sw_pulse(16'h7FFF);
    check("sw_pending_set", 32'(sw_pending_o), 1);
    check("sw_mix_level", 32'(fifo_level_o), 2);
    exp_strobe(16'h7FFF);
    exp_strobe(16'h0A00);
    exp_strobe(16'h0B00);
    exp_result(24'h0180FD, 1'b1);
    exp_result(24'h001F00, 1'b0);
    exp_result(24'h002200, 1'b0);
    en_i = 1'b1;
    wait_drain(300);
    check("sw_pending_clear", 32'(sw_pending_o), 0);

    // Overwritten software sample
    en_i = 1'b0;
    sw_pulse(16'h1111);
    sw_pulse(16'h2222);
    check("drop_cnt_one", 32'(drop_cnt_o), 1);
    check("sw_pending_overwrite", 32'(sw_pending_o), 1);
    exp_strobe(16'h2222);
    exp_result(24'h006766, 1'b1);
    en_i = 1'b1;
    wait_drain(200);
    check("drop_cnt_kept", 32'(drop_cnt_o), 1);

    // Timeout: FIR never answers the first sample
    en_i     = 1'b0;
    push_stream(16'h0055);
    push_stream(16'h0066);
    fir_mute = 1'b1;
    exp_strobe(16'h0055);
    exp_strobe(16'h0066);
    exp_result(24'h000232, 1'b0);
    en_i = 1'b1;
    c = 0;
    while (!fir_strobe_o && c < 50) begin
      tick();
      c++;
    end
    check("to_first_strobe", 32'(fir_strobe_o), 1);
    c = 0;
    do begin
      tick();
      c++;
      if (c == 1) fir_mute = 1'b0;
    end while (!timeout_o && c < TO + 20);
    check("timeout_set", 32'(timeout_o), 1);
    check("timeout_cycles", 32'(c), 32'(TO + 1));
    check("idle_after_timeout", 32'(busy_o), 0);
    wait_drain(200);
    check("timeout_sticky", 32'(timeout_o), 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_timeout", 32'(timeout_o), 0);
    check("clr_drop", 32'(drop_cnt_o), 0);

    // Backpressure on the result, then reset mid-WAIT
    m_ready_i = 1'b0;
    en_i      = 1'b0;
    push_stream(16'h0100);
    push_stream(16'h0200);
    exp_strobe(16'h0100);
    exp_strobe(16'h0200);
    exp_result(24'h000400, 1'b0);
    s0   = n_strobes;
    en_i = 1'b1;
    c = 0;
    while (!m_valid_o && c < 100) begin
      tick();
      c++;
    end
    check("hold_valid_seen", 32'(m_valid_o), 1);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!m_valid_o || m_y_o !== 24'h000400 || m_src_o !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 1);
    check("hold_one_strobe", 32'(n_strobes - s0), 1);
    check("hold_level", 32'(fifo_level_o), 1);
    m_ready_i = 1'b1;
    c = 0;
    while (!fir_strobe_o && c < 50) begin
      tick();
      c++;
    end
    check("resume_strobe", 32'(fir_strobe_o), 1);
    repeat (3) tick();
    check("busy_in_wait", 32'(busy_o), 1);
    rst_i = 1'b1;
    tick();
    check_reset_outputs();
    tick();
    rst_i = 1'b0;
    saw_valid = 1'b0;
    repeat (20) begin
      tick();
      if (m_valid_o) saw_valid = 1'b1;
    end
    check("late_result_ignored", 32'(saw_valid), 0);
    check("post_reset_s_ready", 32'(s_ready_o), 1);
    check("post_reset_busy", 32'(busy_o), 0);
    check("scoreboard_empty", 32'(exp_smp_q.size() + exp_res_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
